apu_mixer_pipe: RTL and testbench
=================================

Name: apu_mixer_pipe

Overview:
Parametrised, pipelined successor of the APU channel mixer. It sums N_PULSE pulse channels, triangle, noise, DMC and N_EXT linear expansion channels through the NES non-linear pulse and TND curves. It adds per-channel mute, saturation with a sticky clip flag, and a power-of-two boxcar decimator with an output strobe. It sits between the APU channel units and the audio DAC/PWM or sample FIFO.

Parameters:
N_PULSE, 2, number of 4-bit pulse channels (1..4)
N_EXT, 0, number of linear expansion channels (0..4)
EXT_W, 6, width of each expansion input
EXT_GAIN, 1, integer multiplier applied to each expansion sample
OUT_W, 8, output sample width
DECIM, 1, decimation factor; power of two, 1..256

Ports:
nclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pulse  in  N_PULSE x 4  pulse channel levels
triangle  in  4  triangle level
noise  in  4  noise level
dmc  in  7  DMC level
ext  in  N_EXT x EXT_W  expansion levels; unused when N_EXT=0
mute  in  N_PULSE+3+N_EXT  1 = channel forced to 0. Bit order: pulses, triangle, noise, dmc, ext
clip_clr  in  1  clears the sticky clip flag
out  out  OUT_W  decimated mixed sample
out_valid  out  1  one-cycle strobe when out updates
clip  out  1  sticky: set when any mix saturated

Behaviour:
- Reset (async, active-high): all pipeline registers, accumulator, decimation counter, out, out_valid and clip go to 0. The pipeline restarts cleanly when reset is released; no partial sample is emitted.
- Stage 1 (registered, edge k), after mute masking:
  - psum = sum of pulses, width clog2(15*N_PULSE+1).
  - tidx = 3*triangle + 2*noise + dmc, 8 bits, maximum 202.
  - esum = EXT_GAIN * sum of ext.
- Stage 2 (edge k+1): synchronous LUT reads.
  - plut = round(256*95.52*n/(8128+100n)); plut[0]=0, plut[1]=3, plut[30]=66.
  - tlut = round(256*163.67*n/(24329+100n)); tlut[3]=5, tlut[202]=190.
  - esum is delayed one stage to stay aligned.
- Stage 3 (edge k+2): mix = plut + tlut + esum, computed at full width.
  - If mix > 2^OUT_W-1, saturate to 2^OUT_W-1 and set clip.
  - clip_clr clears clip. If clip_clr coincides with a new saturation, set wins.
- Decimator:
  - A free-running counter 0..DECIM-1 advances every cycle once the pipeline is primed. Priming is 3 cycles after reset release, counted from the first valid stage-3 result.
  - acc accumulates the stage-3 sample.
  - When the counter wraps: out = (acc + current sample) >> log2(DECIM), out_valid = 1 for one cycle, acc reloads to 0.
  - acc width is OUT_W + log2(DECIM); it cannot overflow.
- DECIM=1: out = saturated mix registered at edge k+3, out_valid high every cycle after priming.
  - Total latency input -> out: 4 edges (DECIM=1). For DECIM>1 a window of DECIM consecutive stage-3 samples produces one out.
- out holds its value between strobes.
- Mute changes take effect on the sample registered in stage 1 at the same edge; there is no glitch handling beyond this.

Decomposition:
- Package apu_mixer_pkg:
  - pulse and TND LUT widths;
  - constant functions generating the plut/tlut arrays, so the LUT is elaborated and needs no vendor ROM IP;
  - tidx weights 3/2/1 as named constants;
  - function clog2.
- One sub-module: apu_mixer_decim. It contains the accumulator, counter and strobe, and is parametrised by OUT_W and DECIM.

Test Plan:
1. Defaults, reset then pulse={1,0}, others 0 -> out=3 with out_valid high, 4 cycles after the input edge; clip=0.
2. triangle=1, others 0 -> tidx=3, out=5. Then triangle=1 with mute bit for triangle set -> out=0.
3. All max (pulses 15, triangle 15, noise 15, dmc 127) -> mix=66+190=256, out=255, clip=1. Inputs return to 0 -> clip stays 1. clip_clr pulse -> clip=0. clip_clr in the same cycle as a new saturation -> clip=1.
4. DECIM=4, pulse={15,15} for 2 cycles then 0 for 2 cycles, aligned to the window -> exactly one out_valid per 4 cycles, out=(66+66+0+0)>>2=33.
5. N_EXT=1, EXT_W=6, EXT_GAIN=2, ext=63, others 0 -> out=126. Add max pulses and TND -> saturation to 255, clip=1.
6. Assert reset mid-window with DECIM=4 and accumulating data -> out, out_valid, clip and acc are 0 immediately. After release, the first strobe arrives only after priming plus 4 full cycles, with no stale contribution.

Source files
------------

// File: rtl/apu_mixer_pkg.sv
// Shared constants and elaboration-time LUT generators for the APU mixer.
// The LUTs become constant vectors, so no ROM macro is needed.
package apu_mixer_pkg;

  localparam int PLUT_W = 8;
  localparam int TLUT_W = 8;
  localparam int TIDX_W = 8;

  localparam int PLUT_DEPTH = 61;
  localparam int TLUT_DEPTH = 203;

  localparam int TRI_WEIGHT   = 3;
  localparam int NOISE_WEIGHT = 2;
  localparam int DMC_WEIGHT   = 1;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Fixed-point form of round(256*95.52*n/(8128+100n)), numerator and denominator scaled by 100.
  function automatic logic [PLUT_DEPTH*PLUT_W-1:0] plutTable();
    logic [PLUT_DEPTH*PLUT_W-1:0] table_v;
    longint num;
    longint den;
    table_v = '0;
    for (int n = 0; n < PLUT_DEPTH; n++) begin
      num = 64'd2445312 * longint'(n);
      den = 64'd812800 + 64'd10000 * longint'(n);
      table_v[n*PLUT_W +: PLUT_W] = PLUT_W'((2 * num + den) / (2 * den));
    end
    return table_v;
  endfunction

  function automatic logic [TLUT_DEPTH*TLUT_W-1:0] tlutTable();
    logic [TLUT_DEPTH*TLUT_W-1:0] table_v;
    longint num;
    longint den;
    table_v = '0;
    for (int n = 0; n < TLUT_DEPTH; n++) begin
      num = 64'd4189952 * longint'(n);
      den = 64'd2432900 + 64'd10000 * longint'(n);
      table_v[n*TLUT_W +: TLUT_W] = TLUT_W'((2 * num + den) / (2 * den));
    end
    return table_v;
  endfunction

endpackage

// File: rtl/apu_mixer_decim.sv
// Power-of-two boxcar decimator: averages DECIM consecutive valid samples
// and strobes out_valid_o for one cycle per window.
module apu_mixer_decim
  import apu_mixer_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int DECIM = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OUT_W-1:0] sample_i,
  input  logic             valid_i,
  output logic [OUT_W-1:0] out_o,
  output logic             out_valid_o
);

  localparam int LOG_D = clog2(DECIM);
  localparam int CNT_W = (LOG_D > 0) ? LOG_D : 1;
  localparam int ACC_W = OUT_W + LOG_D;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             outValid_q, outValid_d;
  logic             wrap;

  assign sum  = acc_q + ACC_W'(sample_i);
  assign wrap = (cnt_q == CNT_W'(DECIM - 1));

  // The window closes on the current sample, so it is folded into the average directly.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    outValid_d = 1'b0;
    if (valid_i) begin
      if (wrap) begin
        out_d      = OUT_W'(sum >> LOG_D);
        outValid_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = outValid_q;

endmodule

// File: rtl/apu_mixer_pipe.sv
// Pipelined NES APU mixer: masked channel sums, non-linear pulse/TND LUTs,
// linear expansion channels, saturation with sticky clip, then decimation.
module apu_mixer_pipe
  import apu_mixer_pkg::*;
#(
  parameter int N_PULSE  = 2,
  parameter int N_EXT    = 0,
  parameter int EXT_W    = 6,
  parameter int EXT_GAIN = 1,
  parameter int OUT_W    = 8,
  parameter int DECIM    = 1
) (
  input  logic                                          nclk,
  input  logic                                          reset,
  input  logic [N_PULSE-1:0][3:0]                       pulse,
  input  logic [3:0]                                    triangle,
  input  logic [3:0]                                    noise,
  input  logic [6:0]                                    dmc,
  input  logic [((N_EXT > 0) ? N_EXT : 1)-1:0][EXT_W-1:0] ext,
  input  logic [N_PULSE+2+N_EXT:0]                      mute,
  input  logic                                          clip_clr,
  output logic [OUT_W-1:0]                              out,
  output logic                                          out_valid,
  output logic                                          clip
);

  localparam int PSUM_W   = clog2(15 * N_PULSE + 1);
  localparam int ESUM_MAX = N_EXT * ((1 << EXT_W) - 1) * EXT_GAIN;
  localparam int ESUM_W   = (ESUM_MAX > 0) ? clog2(ESUM_MAX + 1) : 1;
  localparam int WIDEST_A = (ESUM_W > TLUT_W) ? ESUM_W : TLUT_W;
  localparam int MIX_W    = ((WIDEST_A > OUT_W) ? WIDEST_A : OUT_W) + 2;

  localparam logic [PLUT_DEPTH*PLUT_W-1:0] PLUT_ROM = plutTable();
  localparam logic [TLUT_DEPTH*TLUT_W-1:0] TLUT_ROM = tlutTable();
  localparam logic [MIX_W-1:0]             OUT_MAX  = MIX_W'((1 << OUT_W) - 1);

  logic [PSUM_W-1:0] psum_q, psum_d;
  logic [TIDX_W-1:0] tidx_q, tidx_d;
  logic [ESUM_W-1:0] esum1_q, esum1_d, esum2_q;
  logic [PLUT_W-1:0] plut_q;
  logic [TLUT_W-1:0] tlut_q;
  logic [MIX_W-1:0]  mix;
  logic              sat;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              clip_q, clip_d;
  logic [2:0]        vld_q;

  generate
    if (N_EXT == 0) begin : g_noExt
      logic unusedExt;
      assign unusedExt = ^ext;
    end
  endgenerate

  // Stage 1 inputs: a muted channel simply contributes zero to its sum.
  always_comb begin
    psum_d  = '0;
    tidx_d  = '0;
    esum1_d = '0;
    for (int i = 0; i < N_PULSE; i++) begin
      if (!mute[i]) psum_d = psum_d + PSUM_W'(pulse[i]);
    end
    if (!mute[N_PULSE])     tidx_d = tidx_d + TIDX_W'(TRI_WEIGHT) * TIDX_W'(triangle);
    if (!mute[N_PULSE + 1]) tidx_d = tidx_d + TIDX_W'(NOISE_WEIGHT) * TIDX_W'(noise);
    if (!mute[N_PULSE + 2]) tidx_d = tidx_d + TIDX_W'(DMC_WEIGHT) * TIDX_W'(dmc);
    for (int i = 0; i < N_EXT; i++) begin
      if (!mute[N_PULSE + 3 + i]) esum1_d = esum1_d + ESUM_W'(ext[i]) * ESUM_W'(EXT_GAIN);
    end
  end

  assign mix      = MIX_W'(plut_q) + MIX_W'(tlut_q) + MIX_W'(esum2_q);
  assign sat      = (mix > OUT_MAX);
  assign sample_d = sat ? {OUT_W{1'b1}} : mix[OUT_W-1:0];
  assign clip_d   = sat | (clip_q & ~clip_clr);

  // vld_q marks which stages hold real data so the decimator starts on a clean window.
  always_ff @(posedge nclk or posedge reset) begin
    if (reset) begin
      psum_q   <= '0;
      tidx_q   <= '0;
      esum1_q  <= '0;
      plut_q   <= '0;
      tlut_q   <= '0;
      esum2_q  <= '0;
      sample_q <= '0;
      clip_q   <= 1'b0;
      vld_q    <= '0;
    end else begin
      psum_q   <= psum_d;
      tidx_q   <= tidx_d;
      esum1_q  <= esum1_d;
      plut_q   <= PLUT_ROM[int'(psum_q)*PLUT_W +: PLUT_W];
      tlut_q   <= TLUT_ROM[int'(tidx_q)*TLUT_W +: TLUT_W];
      esum2_q  <= esum1_q;
      sample_q <= sample_d;
      clip_q   <= clip_d;
      vld_q    <= {vld_q[1:0], 1'b1};
    end
  end

  apu_mixer_decim #(
    .OUT_W(OUT_W),
    .DECIM(DECIM)
  ) u_decim (
    .clk_i      (nclk),
    .rst_i      (reset),
    .sample_i   (sample_q),
    .valid_i    (vld_q[2]),
    .out_o      (out),
    .out_valid_o(out_valid)
  );

  assign clip = clip_q;

endmodule

// File: tb/tb_apu_mixer_pipe.sv
// Self-checking bench: a default mixer (A) and an expansion/decimating mixer (B)
// share stimulus and are compared every cycle against a behavioural model.
module tb_apu_mixer_pipe;

  localparam int HIST = 16384;

  logic             nclk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0][3:0]  pulse;
  logic [3:0]       triangle;
  logic [3:0]       noise;
  logic [6:0]       dmc;
  logic [0:0][5:0]  ext;
  logic [5:0]       mute;
  logic             clip_clr;

  logic [7:0] outA, outB;
  logic       validA, validB, clipA, clipB;

  int tests = 0;
  int failures = 0;

  always #5 nclk = ~nclk;

  apu_mixer_pipe #(
    .N_PULSE(2), .N_EXT(0), .EXT_W(6), .EXT_GAIN(1), .OUT_W(8), .DECIM(1)
  ) dutA (
    .nclk(nclk), .reset(reset), .pulse(pulse), .triangle(triangle), .noise(noise),
    .dmc(dmc), .ext(ext), .mute(mute[4:0]), .clip_clr(clip_clr),
    .out(outA), .out_valid(validA), .clip(clipA)
  );

  apu_mixer_pipe #(
    .N_PULSE(2), .N_EXT(1), .EXT_W(6), .EXT_GAIN(2), .OUT_W(8), .DECIM(4)
  ) dutB (
    .nclk(nclk), .reset(reset), .pulse(pulse), .triangle(triangle), .noise(noise),
    .dmc(dmc), .ext(ext), .mute(mute), .clip_clr(clip_clr),
    .out(outB), .out_valid(validB), .clip(clipB)
  );

  // Reference curves taken straight from the NES mixer formulas in floating point.
  function automatic int lutP(input int n);
    real v;
    v = 256.0 * 95.52 * n / (8128.0 + 100.0 * n);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int lutT(input int n);
    real v;
    v = 256.0 * 163.67 * n / (24329.0 + 100.0 * n);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int mixOf(input bit useExt, input int gain);
    int ps;
    int ti;
    int ex;
    ps = (mute[0] ? 0 : int'(pulse[0])) + (mute[1] ? 0 : int'(pulse[1]));
    ti = 3 * (mute[2] ? 0 : int'(triangle)) + 2 * (mute[3] ? 0 : int'(noise))
       + (mute[4] ? 0 : int'(dmc));
    ex = (useExt && !mute[5]) ? gain * int'(ext[0]) : 0;
    return lutP(ps) + lutT(ti) + ex;
  endfunction

  int histA [HIST];
  int histB [HIST];
  bit satA  [HIST];
  bit satB  [HIST];
  int edgeCnt;
  int expOutA, expOutB;
  bit expValidA, expValidB, expClipA, expClipB;

  // Model: sample j (captured at edge j) leaves the pipeline at edge j+3,
  // saturation of sample j sets clip at edge j+2.
  always @(posedge nclk or posedge reset) begin
    if (reset) begin
      edgeCnt   = 0;
      expOutA   = 0;
      expOutB   = 0;
      expValidA = 0;
      expValidB = 0;
      expClipA  = 0;
      expClipB  = 0;
    end else if (edgeCnt < HIST) begin
      int e, mA, mB, s;
      e = edgeCnt;
      mA = mixOf(1'b0, 1);
      mB = mixOf(1'b1, 2);
      histA[e] = (mA > 255) ? 255 : mA;
      satA[e]  = (mA > 255);
      histB[e] = (mB > 255) ? 255 : mB;
      satB[e]  = (mB > 255);
      if (e >= 2 && satA[e-2]) expClipA = 1; else if (clip_clr) expClipA = 0;
      if (e >= 2 && satB[e-2]) expClipB = 1; else if (clip_clr) expClipB = 0;
      expValidA = 0;
      if (e >= 3) begin
        expValidA = 1;
        expOutA   = histA[e-3];
      end
      expValidB = 0;
      if (e >= 3 && ((e - 3) % 4) == 3) begin
        s = 0;
        for (int k = e - 6; k <= e - 3; k++) s = s + histB[k];
        expOutB   = s / 4;
        expValidB = 1;
      end
      edgeCnt = edgeCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests = tests + 1;
    if (actual != expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge nclk) begin
    #1;
    checkOutput("outA", int'(outA), expOutA);
    checkOutput("validA", int'(validA), int'(expValidA));
    checkOutput("clipA", int'(clipA), int'(expClipA));
    checkOutput("outB", int'(outB), expOutB);
    checkOutput("validB", int'(validB), int'(expValidB));
    checkOutput("clipB", int'(clipB), int'(expClipB));
  end

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge nclk);
      #2;
    end
  endtask

  task automatic applyStimulus(input int p0, input int p1, input int triVal, input int noiVal,
                               input int dmcVal, input int extVal, input logic [5:0] m,
                               input logic clr);
    pulse[0] = 4'(p0);
    pulse[1] = 4'(p1);
    triangle = 4'(triVal);
    noise    = 4'(noiVal);
    dmc      = 7'(dmcVal);
    ext[0]   = 6'(extVal);
    mute     = m;
    clip_clr = clr;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    reset = 1'b1;
    waitEdges(3);

    // Single pulse level of 1 appears after four edges.
    applyStimulus(1, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    reset = 1'b0;
    waitEdges(3);
    checkOutput("t1_valid_early", int'(validA), 0);
    waitEdges(1);
    checkOutput("t1_out", int'(outA), 3);
    checkOutput("t1_valid", int'(validA), 1);
    checkOutput("t1_clip", int'(clipA), 0);

    applyStimulus(0, 0, 1, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(5);
    checkOutput("t2_triangle", int'(outA), 5);
    applyStimulus(0, 0, 1, 0, 0, 0, 6'b000100, 1'b0);
    waitEdges(5);
    checkOutput("t2_muted", int'(outA), 0);

    applyStimulus(15, 15, 15, 15, 127, 0, 6'b0, 1'b0);
    waitEdges(5);
    checkOutput("t3_sat_out", int'(outA), 255);
    checkOutput("t3_clip_set", int'(clipA), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(5);
    checkOutput("t3_clip_sticky", int'(clipA), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b1);
    waitEdges(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    checkOutput("t3_clip_cleared", int'(clipA), 0);
    applyStimulus(15, 15, 15, 15, 127, 0, 6'b0, 1'b0);
    waitEdges(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b1);
    waitEdges(1);
    checkOutput("t3_set_wins", int'(clipA), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b1);
    waitEdges(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    checkOutput("t3_clip_cleared2", int'(clipA), 0);

    // Window-aligned decimation on B: 66,66,0,0 averages to 33.
    applyStimulus(15, 15, 0, 0, 0, 0, 6'b0, 1'b0);
    reset = 1'b1;
    waitEdges(2);
    reset = 1'b0;
    waitEdges(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(4);
    checkOutput("t4_no_early_strobe", int'(validB), 0);
    waitEdges(1);
    checkOutput("t4_avg", int'(outB), 33);
    checkOutput("t4_strobe", int'(validB), 1);
    waitEdges(1);
    checkOutput("t4_strobe_one_cycle", int'(validB), 0);
    checkOutput("t4_hold", int'(outB), 33);

    applyStimulus(0, 0, 0, 0, 0, 63, 6'b0, 1'b0);
    waitEdges(12);
    checkOutput("t5_ext", int'(outB), 126);
    applyStimulus(15, 15, 15, 15, 127, 63, 6'b0, 1'b0);
    waitEdges(12);
    checkOutput("t5_ext_sat", int'(outB), 255);
    checkOutput("t5_ext_clip", int'(clipB), 1);

    // Reset in the middle of an accumulating window.
    applyStimulus(0, 0, 0, 0, 0, 63, 6'b0, 1'b0);
    waitEdges(9);
    @(posedge nclk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t6_outB_zero", int'(outB), 0);
    checkOutput("t6_validB_zero", int'(validB), 0);
    checkOutput("t6_clipB_zero", int'(clipB), 0);
    checkOutput("t6_outA_zero", int'(outA), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(2);
    reset = 1'b0;
    waitEdges(6);
    checkOutput("t6_no_early_strobe", int'(validB), 0);
    waitEdges(1);
    checkOutput("t6_fresh_avg", int'(outB), 3);
    checkOutput("t6_fresh_strobe", int'(validB), 1);

    for (int c = 0; c < 1500; c++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                    ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'b0,
                    ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        waitEdges(2);
        reset = 1'b0;
      end
      waitEdges(1);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 6'b0, 1'b0);
    waitEdges(2);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
